// File: rtl/mfp_ahb_lite_master.sv
// Purpose: turns single read/write commands into one AHB-Lite SINGLE transfer each (no pipelining).
// Latency: accept edge N -> NONSEQ in N+1 -> data phase N+2 -> rsp_valid N+3 (misaligned: rsp_valid N+1).
// Backpressure: cmd_ready only in idle; slave HREADY stretches address/data phases; rsp_valid cannot stall.
module mfp_ahb_lite_master #(
   parameter int         WAIT_W    = 8,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   // command side
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [31:0]       cmd_addr,
   input  logic [31:0]       cmd_wdata,
   input  logic [2:0]        cmd_size,
   // response side
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_error,
   output logic [WAIT_W-1:0] rsp_waits,
   // AHB-Lite master
   output logic [31:0]       HADDR,
   output logic [2:0]        HBURST,
   output logic              HMASTLOCK,
   output logic [3:0]        HPROT,
   output logic [2:0]        HSIZE,
   output logic [1:0]        HTRANS,
   output logic [31:0]       HWDATA,
   output logic              HWRITE,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

   state_t            state_q;
   logic              write_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic [2:0]        size_q;
   logic [1:0]        htrans_q;
   logic [31:0]       hwdata_q;
   logic              rsp_valid_q;
   logic [31:0]       rsp_rdata_q;
   logic              rsp_error_q;
   logic [WAIT_W-1:0] rsp_waits_q;
   logic [WAIT_W-1:0] wait_cnt_q;
   logic [WAIT_W-1:0] wait_cnt_d;
   logic              misaligned;

   // Commands the bus cannot express as one naturally aligned beat are bounced without a transfer.
   always_comb begin
      misaligned = (cmd_size > 3'd2)
                || ((cmd_size == 3'd1) && cmd_addr[0])
                || ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));
   end

   // Saturating next value of the data-phase wait counter.
   always_comb begin
      wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
   end

   // Transfer sequencer; every bus and response output is a register updated here.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q     <= S_IDLE;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         htrans_q    <= TRANS_IDLE;
         hwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_error_q <= 1'b0;
         rsp_waits_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  write_q    <= cmd_write;
                  addr_q     <= cmd_addr;
                  wdata_q    <= cmd_wdata;
                  size_q     <= cmd_size;
                  wait_cnt_q <= '0;
                  if (misaligned) begin
                     // rsp_rdata deliberately keeps the last read value
                     state_q     <= S_RESP;
                     rsp_valid_q <= 1'b1;
                     rsp_error_q <= 1'b1;
                     rsp_waits_q <= '0;
                  end else begin
                     state_q  <= S_ADDR;
                     htrans_q <= TRANS_NONSEQ;
                  end
               end
            end
            S_ADDR: begin
               // address phase ends only when the bus is ready
               if (HREADY) begin
                  state_q  <= S_DATA;
                  htrans_q <= TRANS_IDLE;
                  if (write_q) begin
                     hwdata_q <= wdata_q;
                  end
               end
            end
            S_DATA: begin
               // HRESP with HREADY low is the first error cycle: just another wait
               if (HREADY) begin
                  if (!write_q) begin
                     rsp_rdata_q <= HRDATA;
                  end
                  rsp_error_q <= HRESP;
                  rsp_waits_q <= wait_cnt_q;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_error = rsp_error_q;
   assign rsp_waits = rsp_waits_q;

   assign HADDR     = addr_q;
   assign HWRITE    = write_q;
   assign HSIZE     = size_q;
   assign HTRANS    = htrans_q;
   assign HWDATA    = hwdata_q;
   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = HPROT_VAL;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Purpose: randomized bench for mfp_ahb_lite_master with a reactive AHB slave and a response scoreboard.
// Latency: expected completion cycle is computed per command from phase lengths and compared at rsp_valid.
// Backpressure: slave stalls address and data phases; commands are also offered while the master is busy.
module tb_mfp_ahb_lite_master;

   localparam int WAIT_W = 8;

   logic              HCLK = 1'b0;
   logic              HRESETn;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [31:0]       cmd_addr;
   logic [31:0]       cmd_wdata;
   logic [2:0]        cmd_size;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_error;
   logic [WAIT_W-1:0] rsp_waits;
   logic [31:0]       HADDR;
   logic [2:0]        HBURST;
   logic              HMASTLOCK;
   logic [3:0]        HPROT;
   logic [2:0]        HSIZE;
   logic [1:0]        HTRANS;
   logic [31:0]       HWDATA;
   logic              HWRITE;
   logic [31:0]       HRDATA;
   logic              HREADY;
   logic              HRESP;

   mfp_ahb_lite_master #(.WAIT_W(WAIT_W), .HPROT_VAL(4'b0011)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .rsp_waits(rsp_waits),
      .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE),
      .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  waits;
      int          cyc;
   } exp_t;

   exp_t        expq[$];
   int          tests = 0;
   int          fails = 0;
   logic        mon_en = 1'b0;
   logic [31:0] mdl_rdata = '0;   // read data the model says the DUT currently holds
   logic [31:0] last_rdata = '0;  // response fields the monitor expects to be held
   logic        last_err = 1'b0;
   logic [7:0]  last_waits = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: pops on each response pulse, and checks held fields every cycle.
   always @(negedge HCLK) begin : monitor
      exp_t e;
      #2;
      if (mon_en) begin
         if (rsp_valid) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rsp_unexpected: got rsp_valid=1 expected none (cycle %0d)", cyc);
            end else begin
               e = expq.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
               last_rdata = e.rdata;
               last_err   = e.err;
               last_waits = e.waits;
            end
         end
         chk("rsp_rdata", rsp_rdata, last_rdata);
         chk("rsp_error", 32'(rsp_error), 32'(last_err));
         chk("rsp_waits", 32'(rsp_waits), 32'(last_waits));
      end
   end

   // One command end to end; starts and returns on a negedge. abort_at >= 0 resets in that data cycle.
   task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, input int stall, input int waits,
                         input logic err, input logic [31:0] rdata, input int abort_at);
      logic mis;
      int   n;
      exp_t e;
      mis = (size > 3'd2) || ((addr % (32'd1 << size)) != 32'd0);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      cmd_size  = size;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge HCLK);
         n++;
      end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'h1);
      if (!cmd_ready) begin
         cmd_valid = 1'b0;
         return;
      end
      if (abort_at < 0) begin
         if (!mis && !wr) mdl_rdata = rdata;
         e.rdata = mdl_rdata;
         e.err   = mis | err;
         e.waits = mis ? 8'd0 : 8'((waits > 255) ? 255 : waits);
         e.cyc   = cyc + 1 + (mis ? 0 : 2 + stall + waits);
         expq.push_back(e);
      end
      @(negedge HCLK);
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_size  = 3'($urandom);
      if (mis) begin
         chk("htrans_reject", 32'(HTRANS), 32'h0);
         cmd_valid = 1'b0;
         return;
      end
      for (int i = 0; i <= stall; i++) begin
         chk("htrans_addr", 32'(HTRANS), 32'h2);
         chk("haddr_addr", HADDR, addr);
         chk("hwrite_addr", 32'(HWRITE), 32'(wr));
         chk("hsize_addr", 32'(HSIZE), 32'(size));
         chk("hburst", 32'(HBURST), 32'h0);
         chk("hprot", 32'(HPROT), 32'h3);
         chk("hmastlock", 32'(HMASTLOCK), 32'h0);
         HREADY    = (i == stall);
         HRESP     = 1'b0;
         cmd_valid = 1'($urandom);
         cmd_addr  = $urandom;
         @(negedge HCLK);
      end
      for (int j = 0; j <= waits; j++) begin
         chk("htrans_data", 32'(HTRANS), 32'h0);
         chk("haddr_data", HADDR, addr);
         chk("hwrite_data", 32'(HWRITE), 32'(wr));
         chk("hsize_data", 32'(HSIZE), 32'(size));
         if (wr) chk("hwdata", HWDATA, wdata);
         if (j == abort_at) begin
            HRESETn   = 1'b0;
            HREADY    = 1'b0;
            @(negedge HCLK);
            HRESETn   = 1'b1;
            HREADY    = 1'b1;
            HRESP     = 1'b0;
            cmd_valid = 1'b0;
            mdl_rdata  = '0;
            last_rdata = '0;
            last_err   = 1'b0;
            last_waits = '0;
            chk("htrans_after_rst", 32'(HTRANS), 32'h0);
            chk("cmd_ready_after_rst", 32'(cmd_ready), 32'h1);
            chk("haddr_after_rst", HADDR, 32'h0);
            chk("rsp_valid_after_rst", 32'(rsp_valid), 32'h0);
            return;
         end
         HREADY    = (j == waits);
         HRESP     = err && (j + 1 >= waits);
         HRDATA    = (j == waits) ? rdata : $urandom;
         cmd_valid = 1'($urandom);
         cmd_addr  = $urandom;
         @(negedge HCLK);
      end
      HREADY    = 1'b1;
      HRESP     = 1'b0;
      cmd_valid = 1'b0;
      chk("htrans_resp", 32'(HTRANS), 32'h0);
   endtask

   initial begin
      HRESETn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_size  = '0;
      HRDATA    = '0;
      HREADY    = 1'b1;
      HRESP     = 1'b0;
      repeat (3) @(negedge HCLK);
      chk("rst_htrans", 32'(HTRANS), 32'h0);
      chk("rst_haddr", HADDR, 32'h0);
      chk("rst_hwrite", 32'(HWRITE), 32'h0);
      chk("rst_hsize", 32'(HSIZE), 32'h0);
      chk("rst_hwdata", HWDATA, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_error", 32'(rsp_error), 32'h0);
      chk("rst_rsp_waits", 32'(rsp_waits), 32'h0);
      HRESETn = 1'b1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
      mon_en = 1'b1;

      // zero-wait write
      do_txn(1'b1, 32'h10, 32'hA5A5_0001, 3'd2, 0, 0, 1'b0, 32'h0, -1);
      // read with two data-phase waits
      do_txn(1'b0, 32'h20, $urandom, 3'd2, 0, 2, 1'b0, 32'h1234_5678, -1);
      // three-cycle address-phase stall
      do_txn(1'b0, 32'h30, $urandom, 3'd2, 3, 0, 1'b0, 32'hCAFE_F00D, -1);
      // two-cycle error response on a write
      do_txn(1'b1, 32'h44, 32'hDEAD_BEEF, 3'd2, 0, 1, 1'b1, 32'h0, -1);
      // rejections: word at 0x6, size 3, odd halfword; then a legal odd byte read
      do_txn(1'b0, 32'h6, $urandom, 3'd2, 0, 0, 1'b0, 32'h1111_1111, -1);
      do_txn(1'b1, 32'h8, $urandom, 3'd3, 0, 0, 1'b0, 32'h0, -1);
      do_txn(1'b0, 32'h3, $urandom, 3'd1, 0, 0, 1'b0, 32'h2222_2222, -1);
      do_txn(1'b0, 32'h3, $urandom, 3'd0, 1, 1, 1'b0, 32'h0000_00AB, -1);
      // reset while the data phase is stalled
      do_txn(1'b0, 32'h100, $urandom, 3'd2, 0, 10, 1'b0, 32'h7777_7777, 3);
      // wait counter saturation
      do_txn(1'b0, 32'h104, $urandom, 3'd2, 0, 300, 1'b0, 32'h55AA_55AA, -1);

      for (int k = 0; k < 80; k++) begin
         logic        wr;
         logic [2:0]  sz;
         logic [31:0] ad;
         int          st;
         int          wt;
         logic        er;
         wr = 1'($urandom);
         sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
         ad = $urandom;
         if ($urandom_range(0, 3) != 0) ad = ad & ~32'h3;
         st = $urandom_range(0, 3);
         wt = $urandom_range(0, 4);
         er = ($urandom_range(0, 3) == 0);
         if (er && wt == 0) wt = 1;
         do_txn(wr, ad, $urandom, sz, st, wt, er, $urandom, -1);
         repeat ($urandom_range(0, 2)) @(negedge HCLK);
      end

      repeat (5) @(negedge HCLK);
      chk("queue_drained", 32'(expq.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mfp_ahb_lite_master.md
MFP_AHB_LITE_MASTER -- requirements
Module: mfp_ahb_lite_master

Interface
REQ-001 SHALL have parameter WAIT_W, default 8, meaning the width of the saturating wait-state counter.
REQ-002 SHALL have parameter HPROT_VAL, default 4'b0011, meaning the constant HPROT value (non-cacheable data, privileged).
REQ-003 SHALL have port HCLK, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port HRESETn, input, 1, synchronous active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1, meaning a command is accepted this cycle if cmd_valid=1.
REQ-007 SHALL have port cmd_write, input, 1, where 1 = write and 0 = read.
REQ-008 SHALL have ports cmd_addr (input, 32, byte address), cmd_wdata (input, 32, write data) and cmd_size (input, 3, AHB HSIZE encoding).
REQ-009 SHALL have port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have ports rsp_rdata (output, 32, read data), rsp_error (output, 1, error/reject flag) and rsp_waits (output, WAIT_W, data-phase wait count).
REQ-011 SHALL have AHB-Lite outputs HADDR (32), HBURST (3), HMASTLOCK (1), HPROT (4), HSIZE (3), HTRANS (2), HWDATA (32) and HWRITE (1).
REQ-012 SHALL have AHB-Lite inputs HRDATA (32), HREADY (1, bus-level ready) and HRESP (1).

Function
REQ-013 SHALL drive HBURST=3'b000 (SINGLE), HMASTLOCK=0 and HPROT=HPROT_VAL constantly.
REQ-014 SHALL implement states S_IDLE, S_ADDR, S_DATA and S_RESP, with one outstanding transfer and no pipelining.
REQ-015 SHALL assert cmd_ready=1 only in S_IDLE.
REQ-016 SHALL, on acceptance (cmd_valid and cmd_ready at an edge), latch write, addr, wdata and size into registers.
REQ-017 SHALL reject a misaligned command: size>2, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
REQ-018 SHALL, for a rejected command, start no bus transfer, go S_IDLE->S_RESP, and report rsp_error=1, rsp_waits=0 and rsp_rdata unchanged.
REQ-019 SHALL, for an aligned accepted command, go S_IDLE->S_ADDR.
REQ-020 SHALL, in S_ADDR, drive registered HTRANS=NONSEQ (2'b10) with HADDR, HWRITE and HSIZE from the latched command.
REQ-021 SHALL hold S_ADDR while HREADY=0 and go to S_DATA on an edge with HREADY=1.
REQ-022 SHALL, in every state other than S_ADDR, drive HTRANS=IDLE (2'b00), and SHALL never issue BUSY or SEQ.
REQ-023 SHALL hold HADDR, HWRITE and HSIZE stable from S_ADDR through the end of S_DATA, changing them only at the next accept.
REQ-024 SHALL, in S_DATA, drive HWDATA=latched wdata for writes and hold it stable until S_DATA exits.
REQ-025 SHALL, in S_DATA, increment a wait counter (cleared at accept) on each edge with HREADY=0, saturating at 2^WAIT_W-1.
REQ-026 SHALL, on an S_DATA edge with HREADY=1, capture HRDATA (reads only; writes leave rsp_rdata unchanged) and HRESP into rsp_error, then go to S_RESP.
REQ-027 SHALL take no action on an error first cycle (HRESP=1, HREADY=0); only the HREADY=1 cycle completes the transfer.
REQ-028 SHALL, in S_RESP, hold rsp_valid=1 for exactly one cycle and then go to S_IDLE.
REQ-029 SHALL keep rsp_rdata, rsp_error and rsp_waits stable from S_RESP until the next completion.
REQ-030 SHALL have zero-wait latency of accept edge N → S_ADDR in cycle N+1 → S_DATA in N+2 → rsp_valid in N+3, giving a minimum of 4 cycles per transfer.
REQ-031 SHALL have rejection latency of accept edge N → rsp_valid in cycle N+1.
REQ-032 SHALL ignore cmd_valid outside S_IDLE, and SHALL allow a command offered during S_RESP to be accepted the following cycle.

Reset
REQ-033 SHALL, while HRESETn=0 at an edge, set the state to S_IDLE.
REQ-034 SHALL reset HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_waits=0 and the wait counter to 0.
REQ-035 SHALL give cmd_ready=1 in the first cycle after reset deasserts.
REQ-036 SHALL, on reset mid-transfer (S_ADDR or S_DATA), abandon the transfer with no rsp_valid and drive HTRANS=IDLE from the cycle after the reset edge.

Verification
REQ-037 SHALL test zero-wait write: cmd write addr=0x10 data=0xA5A5_0001 size=2 at N with HREADY=1 -> HTRANS=NONSEQ and HADDR=0x10 in N+1, HWDATA=0xA5A5_0001 in N+2, rsp_valid in N+3 with rsp_error=0 and rsp_waits=0.
REQ-038 SHALL test a waited read: slave holds HREADY=0 for 2 data-phase cycles then returns HRDATA=0x1234_5678 -> rsp_rdata=0x1234_5678, rsp_waits=2, rsp_valid in N+5, HADDR stable throughout.
REQ-039 SHALL test address-phase stall: HREADY=0 for 3 cycles in S_ADDR -> HTRANS=NONSEQ held 4 cycles with HADDR unchanged, rsp_waits=0.
REQ-040 SHALL test error response: HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> rsp_error=1, rsp_waits=1, HTRANS=IDLE in both cycles.
REQ-041 SHALL test misalignment: cmd size=2 addr=0x6 -> HTRANS stays IDLE, rsp_valid at N+1 with rsp_error=1 and rsp_waits=0; cmd size=3 is rejected the same way.
REQ-042 SHALL test reset in S_DATA: HRESETn=0 for one edge -> no rsp_valid, HTRANS=IDLE and cmd_ready=1 next cycle; 300 wait cycles with WAIT_W=8 -> rsp_waits=255.
